// File: rtl/memory_stage.sv
// MEM pipeline stage: latches the execute bundle, runs one data-memory
// access per load/store, aligns load data and feeds writeback.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_result_alu,
  input  logic [31:0] in_store_data,
  input  logic        in_MemToReg,
  input  logic        in_RegWrite,
  input  logic        in_PCSrc,
  input  logic [4:0]  in_RegDest,
  input  logic [31:0] in_BranchTarget,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] data_mem,
  output logic [31:0] result_alu,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic [4:0]  RegDest,
  output logic [31:0] BranchTarget,
  output logic        busy,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  logic        is_wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic [31:0] tgt;
  logic [31:0] held;
  logic [4:0]  rdst;
  logic        m2r;
  logic        rw;
  logic        pcs;

  logic        in_mem;
  logic        in_mis;
  logic        in_acc;
  logic        acc;
  logic        present;
  logic [31:0] sh;
  logic [31:0] ld;
  logic [31:0] fin;
  logic [31:0] wd;
  logic [3:0]  st;

  assign in_mem = in_MemRead | in_MemWrite;
  assign in_mis = in_mem &
    (((in_funct3[1:0] == 2'b01) & in_result_alu[0]) |
     ((in_funct3[1:0] == 2'b10) & (|in_result_alu[1:0])));
  assign in_acc = in_mem & ~in_mis;

  assign acc     = (state == ACCESS);
  assign present = ~stall & ((acc & mem_ready) | (state == DONE));
  assign busy    = (acc & ~mem_ready) | (state == DONE);

  assign sh = mem_rdata >> {addr[1:0], 3'b000};

  always_comb begin
    ld = '0;
    unique case (1'b1)
      !is_wr && f3 == 3'b000: ld = {{24{sh[7]}}, sh[7:0]};
      !is_wr && f3 == 3'b001: ld = {{16{sh[15]}}, sh[15:0]};
      !is_wr && f3 == 3'b010: ld = sh;
      !is_wr && f3 == 3'b100: ld = {24'd0, sh[7:0]};
      !is_wr && f3 == 3'b101: ld = {16'd0, sh[15:0]};
      default:                ld = '0;
    endcase
  end

  assign fin = (state == DONE) ? held : ld;

  always_comb begin
    wd = sdata;
    st = 4'b1111;
    unique case (1'b1)
      f3[1:0] == 2'b00: begin
        wd = {4{sdata[7:0]}};
        st = 4'b0001 << addr[1:0];
      end
      f3[1:0] == 2'b01: begin
        wd = {2{sdata[15:0]}};
        st = 4'b0011 << addr[1:0];
      end
      default: begin
        wd = sdata;
        st = 4'b1111;
      end
    endcase
  end

  // Bus signals come straight from captured state, so they stay stable
  // for the whole access and vanish as soon as reset forces IDLE.
  assign mem_req   = acc;
  assign mem_we    = acc & is_wr;
  assign mem_addr  = acc ? {addr[31:2], 2'b00} : '0;
  assign mem_wdata = acc ? wd : '0;
  assign mem_wstrb = (acc & is_wr) ? st : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      is_wr        <= 1'b0;
      f3           <= '0;
      addr         <= '0;
      sdata        <= '0;
      tgt          <= '0;
      held         <= '0;
      rdst         <= '0;
      m2r          <= 1'b0;
      rw           <= 1'b0;
      pcs          <= 1'b0;
      data_mem     <= '0;
      result_alu   <= '0;
      MemToReg     <= 1'b0;
      RegWrite     <= 1'b0;
      PCSrc        <= 1'b0;
      RegDest      <= '0;
      BranchTarget <= '0;
      misaligned   <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!stall) begin
            is_wr <= in_MemWrite;
            f3    <= in_funct3;
            addr  <= in_result_alu;
            sdata <= in_store_data;
            tgt   <= in_BranchTarget;
            rdst  <= in_RegDest;
            m2r   <= in_MemToReg;
            rw    <= in_RegWrite;
            pcs   <= in_PCSrc;
            if (in_acc) begin
              state    <= ACCESS;
              data_mem <= '0;
              RegWrite <= 1'b0;
              PCSrc    <= 1'b0;
              MemToReg <= 1'b0;
            end else begin
              data_mem     <= '0;
              result_alu   <= in_result_alu;
              MemToReg     <= in_MemToReg;
              RegWrite     <= in_RegWrite & ~in_mis;
              PCSrc        <= in_PCSrc;
              RegDest      <= in_RegDest;
              BranchTarget <= in_BranchTarget;
              misaligned   <= in_mis;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            held  <= ld;
            state <= stall ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (present) begin
        data_mem     <= fin;
        result_alu   <= addr;
        MemToReg     <= m2r;
        RegWrite     <= rw;
        PCSrc        <= pcs;
        RegDest      <= rdst;
        BranchTarget <= tgt;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table through a scoreboard plus
// hand-written stall and reset sequences.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        in_MemRead;
  logic        in_MemWrite;
  logic [2:0]  in_funct3;
  logic [31:0] in_result_alu;
  logic [31:0] in_store_data;
  logic        in_MemToReg;
  logic        in_RegWrite;
  logic        in_PCSrc;
  logic [4:0]  in_RegDest;
  logic [31:0] in_BranchTarget;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] data_mem;
  logic [31:0] result_alu;
  logic        MemToReg;
  logic        RegWrite;
  logic        PCSrc;
  logic [4:0]  RegDest;
  logic [31:0] BranchTarget;
  logic        busy;
  logic        misaligned;

  memory_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_funct3(in_funct3), .in_result_alu(in_result_alu),
    .in_store_data(in_store_data), .in_MemToReg(in_MemToReg),
    .in_RegWrite(in_RegWrite), .in_PCSrc(in_PCSrc),
    .in_RegDest(in_RegDest), .in_BranchTarget(in_BranchTarget),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .data_mem(data_mem), .result_alu(result_alu),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .RegDest(RegDest), .BranchTarget(BranchTarget),
    .busy(busy), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        rw;
    logic        m2r;
    logic        pcs;
    logic [4:0]  rdst;
    logic [31:0] tgt;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_data;
    logic        e_rw;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] res;
    logic        rw;
    logic [4:0]  rdst;
    logic        m2r;
    logic        pcs;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, data_mem, e.data);
      chk({tag, "_res"}, result_alu, e.res);
      chk({tag, "_rw"}, 32'(RegWrite), 32'(e.rw));
      chk({tag, "_rdst"}, 32'(RegDest), 32'(e.rdst));
      chk({tag, "_m2r"}, 32'(MemToReg), 32'(e.m2r));
      chk({tag, "_pcs"}, 32'(PCSrc), 32'(e.pcs));
      chk({tag, "_tgt"}, BranchTarget, e.tgt);
    end
  endtask

  task automatic drive(input vec_t v);
    in_MemRead      = v.rd;
    in_MemWrite     = v.wr;
    in_funct3       = v.f3;
    in_result_alu   = v.addr;
    in_store_data   = v.sdata;
    in_RegWrite     = v.rw;
    in_MemToReg     = v.m2r;
    in_PCSrc        = v.pcs;
    in_RegDest      = v.rdst;
    in_BranchTarget = v.tgt;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    string t;
    t = $sformatf("v%0d", i);
    @(negedge clk);
    stall = 1'b0;
    mem_ready = 1'b0;
    drive(v);
    sb.push_back('{v.e_data, v.addr, v.e_rw, v.rdst,
                   v.m2r, v.pcs, v.tgt});
    @(posedge clk); #1;
    in_MemRead  = 1'b0;
    in_MemWrite = 1'b0;
    if (!v.e_req) begin
      chk({t, "_noreq"}, 32'(mem_req), 32'd0);
      chk({t, "_mis"}, 32'(misaligned), 32'(v.e_mis));
      cmp_out(t);
      if (v.e_mis) begin
        in_RegWrite = 1'b0;
        @(posedge clk); #1;
        chk({t, "_misend"}, 32'(misaligned), 32'd0);
      end
    end else begin
      chk({t, "_req"}, 32'(mem_req), 32'd1);
      chk({t, "_addr"}, mem_addr, v.e_addr);
      chk({t, "_we"}, 32'(mem_we), 32'(v.wr));
      chk({t, "_strb"}, 32'(mem_wstrb), 32'(v.e_strb));
      if (v.wr) chk({t, "_wdata"}, mem_wdata, v.e_wdata);
      chk({t, "_pcsb"}, 32'(PCSrc), 32'd0);
      chk({t, "_m2rb"}, 32'(MemToReg), 32'd0);
      mem_rdata = v.rdata;
      for (int w = 0; w < v.waits; w++) begin
        chk({t, "_busyw"}, 32'(busy), 32'd1);
        chk({t, "_reqw"}, 32'(mem_req), 32'd1);
        chk({t, "_addrw"}, mem_addr, v.e_addr);
        chk({t, "_rwb"}, 32'(RegWrite), 32'd0);
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      #1;
      chk({t, "_busyr"}, 32'(busy), 32'd0);
      chk({t, "_rwb"}, 32'(RegWrite), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      cmp_out(t);
      chk({t, "_reqoff"}, 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0,
               5'd5, 32'h0, 32'h0, 0,
               32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd7, 32'h0, 32'h80FF_0000, 0,
               32'hFFFF_FF80, 1'b1, 1'b1, 32'h100, 32'h0, 4'b0000, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd8, 32'h0, 32'h80FF_0000, 0,
               32'h0000_0080, 1'b1, 1'b1, 32'h100, 32'h0, 4'b0000, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b0, 1'b0,
               1'b0, 5'd0, 32'h0, 32'h0, 0,
               32'h0, 1'b0, 1'b1, 32'h200, 32'hABCD_ABCD, 4'b1100, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd10, 32'h0, 32'hDEAD_BEEF, 3,
               32'hDEAD_BEEF, 1'b1, 1'b1, 32'h10, 32'h0, 4'b0000, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 1'b1, 1'b1,
               5'd11, 32'h4000, 32'h0, 0,
               32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd12, 32'h0, 32'h8001_0000, 0,
               32'hFFFF_8001, 1'b1, 1'b1, 32'h100, 32'h0, 4'b0000, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd13, 32'h0, 32'h1234_F00D, 1,
               32'h0000_1234, 1'b1, 1'b1, 32'h104, 32'h0, 4'b0000, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_5678, 1'b0, 1'b0,
               1'b0, 5'd0, 32'h0, 32'h0, 0,
               32'h0, 1'b0, 1'b1, 32'h300, 32'h7878_7878, 4'b0010, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 1'b0, 1'b0,
               1'b0, 5'd0, 32'h0, 32'h0, 2,
               32'h0, 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'b1111, 1'b0};
    vt[10] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 1'b1, 1'b0,
               5'd14, 32'h0, 32'h0, 0,
               32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vt[11] = '{1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1,
               5'd0, 32'h8000, 32'h0, 0,
               32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0};

    rst = 1'b0;
    stall = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    in_MemRead = 1'b0;
    in_MemWrite = 1'b0;
    in_funct3 = '0;
    in_result_alu = '0;
    in_store_data = '0;
    in_MemToReg = 1'b0;
    in_RegWrite = 1'b0;
    in_PCSrc = 1'b0;
    in_RegDest = '0;
    in_BranchTarget = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_data", data_mem, 32'd0);
    chk("rst_res", result_alu, 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // stall arrives together with mem_ready: result parked in DONE
    @(negedge clk);
    drive('{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0,
            5'd3, 32'h0, 32'h0, 0,
            32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0});
    sb.push_back('{32'h1111_2222, 32'h20, 1'b1, 5'd3, 1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    in_MemRead = 1'b0;
    in_result_alu = 32'h99;
    in_RegDest = 5'd9;
    in_MemToReg = 1'b0;
    stall = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      chk("done_req", 32'(mem_req), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_rw", 32'(RegWrite), 32'd0);
      chk("done_data", data_mem, 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    sb.push_back('{32'h0, 32'h99, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    cmp_out("done");
    chk("done_busy0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    cmp_out("after_done");

    // IDLE with stall: nothing captured, outputs held
    @(negedge clk);
    stall = 1'b1;
    in_result_alu = 32'h77;
    in_RegDest = 5'd17;
    @(posedge clk); #1;
    chk("istall_res", result_alu, 32'h99);
    chk("istall_rdst", 32'(RegDest), 32'd9);
    stall = 1'b0;
    sb.push_back('{32'h0, 32'h77, 1'b1, 5'd17, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    cmp_out("istall");

    // reset asserted in the middle of an access
    @(negedge clk);
    in_MemRead = 1'b1;
    in_funct3 = 3'b010;
    in_result_alu = 32'h40;
    @(posedge clk); #1;
    in_MemRead = 1'b0;
    chk("rmid_req1", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_req0", 32'(mem_req), 32'd0);
    chk("rmid_addr", mem_addr, 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_res", result_alu, 32'd0);
    chk("rmid_rdst", 32'(RegDest), 32'd0);
    chk("rmid_rw", 32'(RegWrite), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rmid_idle", 32'(mem_req), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage between execute and `writeback`. Latches the execute-stage result and control bundle, performs load/store transactions on a word-wide data-memory bus with a ready handshake, aligns and sign/zero-extends load data, and presents `data_mem`, `result_alu` and the control signals that `writeback` consumes. Requests a global pipeline stall while a memory transaction is outstanding.

## Interface
- No parameters; data path fixed at 32 bits, register index 5 bits.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `stall` input 1: downstream/global stall; stage must not change its writeback-facing outputs while high.
- `in_MemRead`, `in_MemWrite` input 1 each: load / store request from execute.
- `in_funct3` input 3: access size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010).
- `in_result_alu` input 32: ALU result; effective address for memory ops.
- `in_store_data` input 32: rs2 value for stores.
- `in_MemToReg`, `in_RegWrite`, `in_PCSrc` input 1 each; `in_RegDest` input 5; `in_BranchTarget` input 32: pass-through control.
- `mem_req` output 1; `mem_we` output 1; `mem_addr` output 32 (word-aligned); `mem_wdata` output 32; `mem_wstrb` output 4: data-memory bus.
- `mem_rdata` input 32; `mem_ready` input 1: memory response, valid in the cycle `mem_ready`=1.
- `data_mem` output 32: aligned, extended load data (0 for non-loads).
- `result_alu` output 32; `MemToReg`, `RegWrite`, `PCSrc` output 1; `RegDest` output 5; `BranchTarget` output 32: registered bundle to `writeback`.
- `busy` output 1: stall request to hazard unit.
- `misaligned` output 1: one-cycle pulse on dropped misaligned access.

## Operation
- States: IDLE, ACCESS, DONE. Reset → IDLE; all outputs 0, `mem_req`=0.
- Accept edge: state IDLE and `stall`=0. Inputs captured into internal registers.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. No bus transaction; bundle output at accept edge with `RegWrite`=0, `PCSrc` passed through, `data_mem`=0; `misaligned`=1 for the following cycle; stay IDLE.
- Non-memory op (MemRead=MemWrite=0): bundle registered to outputs at accept edge, `data_mem`=0; stay IDLE.
- Aligned memory op: → ACCESS; at same edge outputs become bubble (`RegWrite`=0, `PCSrc`=0, `MemToReg`=0).
- ACCESS: `mem_req`=1, `mem_we`=MemWrite, `mem_addr`={addr[31:2],2'b00}. Store: `mem_wdata` = byte replicated ×4 / half ×2 / word; `mem_wstrb` = 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), 1111 (SW). Load: `mem_wstrb`=0000.
- ACCESS with `mem_ready`=1: load data = `mem_rdata` shifted right by addr[1:0]×8, LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged; stores give 0. If `stall`=0: bundle + data to outputs, → IDLE. If `stall`=1: hold result internally, → DONE.
- DONE: `mem_req`=0; when `stall`=0, present result, → IDLE (no accept on that edge).
- `busy` = (ACCESS && !`mem_ready`) || DONE; combinational.
- IDLE with `stall`=1: outputs held, nothing captured.
- `rst` low at any time (including mid-ACCESS): `mem_req` drops immediately, state IDLE, transaction abandoned.

## Timing
- Non-memory op: 1-cycle latency, accept edge to outputs.
- Load/store with `mem_ready` in first ACCESS cycle: 2 edges (accept → ACCESS → result); `busy` never asserted.
- Each wait cycle with `mem_ready`=0 adds one cycle; `busy`=1 during those cycles.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` stable from ACCESS entry until the `mem_ready` edge; exactly one `mem_ready` consumed per access.

## Test plan
- ADD bundle: `in_result_alu`=0x0000_1234, RegWrite=1, RegDest=5 → next cycle `result_alu`=0x1234, `RegWrite`=1, `RegDest`=5, `mem_req` never 1.
- LB addr 0x103, `mem_rdata`=0x80FF_0000, ready same cycle → `mem_addr`=0x100, `data_mem`=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x202, data 0x0000_ABCD → `mem_wdata`=0xABCD_ABCD, `mem_wstrb`=1100, `mem_we`=1, `RegWrite` out 0.
- LW addr 0x10, `mem_ready` low 3 cycles → `busy`=1 for 3 cycles, outputs bubble, then `data_mem`=`mem_rdata`.
- LW addr 0x12 → no `mem_req`, `misaligned` pulses 1 cycle, `RegWrite`=0.
- `stall` high when `mem_ready` arrives → DONE, outputs unchanged until `stall` low; `rst` low mid-ACCESS → `mem_req`=0 immediately, all outputs 0.
